sample_window: RTL and testbench
================================

# sample_window

Parametrised sliding-window sample buffer. Successor to the fixed 4-bit, 9-stage sample delay line, and the front end of the filtering datapath. Adds configurable width and depth, a qualifying input strobe, and a synchronous flush. Also maintains a running window sum, a fill counter, and a selectable tap, so downstream averaging and FIR logic need no extra adder tree.

## Interface
Parameters:
- DATA_W, default 4: unsigned sample width, ≥1.
- DEPTH, default 9: number of window stages, ≥2.
- Derived SUM_W = DATA_W + $clog2(DEPTH): window sum width.
- Derived TAP_W = $clog2(DEPTH): tap-select width.
- Derived CNT_W = $clog2(DEPTH+1): fill-count width.

Ports (single clock; reset is synchronous and active-high):
- clk  in  1: the only clock; all state updates on posedge.
- reset  in  1: synchronous, active-high; clears all state.
- flush  in  1: synchronous clear command, same effect as reset.
- in_valid  in  1: data_in is accepted at this edge.
- data_in  in  DATA_W: new sample.
- tap_sel  in  TAP_W: tap index for tap_out.
- samples  out  DATA_W*DEPTH: stage k is at bits [k*DATA_W +: DATA_W]; stage 0 is the newest sample.
- tap_out  out  DATA_W: stage tap_sel, combinational from registers.
- win_sum  out  SUM_W: registered sum of all DEPTH stages.
- fill_count  out  CNT_W: number of accepted samples, saturating at DEPTH.
- full  out  1: fill_count == DEPTH.
- out_valid  out  1: registered pulse; the window is complete and has just been updated.

## Operation
- Priority at each edge: reset, then flush, then in_valid, then hold.
- Reset or flush:
  - All stages, win_sum, fill_count and out_valid become 0.
  - A sample presented in the same cycle is dropped.
- Accept (in_valid=1, no reset or flush):
  - stage0 ← data_in; stage k ← stage k-1 for k=1..DEPTH-1.
  - The old stage DEPTH-1 is discarded.
  - win_sum ← win_sum + data_in − old stage DEPTH-1. This is exact, because cleared stages hold 0.
  - fill_count ← min(fill_count+1, DEPTH).
  - out_valid ← 1 if the new fill_count == DEPTH, else 0.
- Idle (in_valid=0): all stages, win_sum and fill_count hold; out_valid ← 0.
- Arithmetic:
  - Unsigned throughout.
  - win_sum never overflows, since its maximum is DEPTH·(2^DATA_W−1) < 2^SUM_W.
  - Intermediate add/subtract is computed at SUM_W+1 bits, then truncated.
- tap_out returns stage tap_sel, or 0 when tap_sel ≥ DEPTH (non-power-of-two DEPTH).
- full is decoded combinationally from fill_count.
- Implicit states: EMPTY (fill 0), FILLING (1..DEPTH-1), FULL (DEPTH).
  - Transitions occur only on accept, reset or flush.
  - FULL is absorbing until reset or flush.

## Timing
- Latency: data_in accepted at edge N is visible on samples stage 0 in cycle N+1. It reaches stage k after k further accepts.
- win_sum, fill_count, full and out_valid all update at the same edge as samples, so they are always mutually consistent.
- out_valid is high for exactly the cycles that follow a qualifying accept. A back-to-back stream with a full window gives a continuous high.
- tap_out has zero latency relative to samples; tap_sel may change every cycle.
- Reset or flush mid-fill: zeros are visible the next cycle. Refill restarts from fill_count 0; the first out_valid follows the DEPTH-th post-clear accept.
- No ready/backpressure: every in_valid is accepted unless reset or flush is asserted.

## Test plan
All scenarios use default parameters (DATA_W=4, DEPTH=9).
- Reset dominance: reset=1 for 2 cycles with in_valid=1, data_in=4'hF → samples all 0, win_sum 0, fill_count 0, full 0, out_valid 0.
- Fill: accept 1..9 back-to-back → after the 9th edge: stage0=9, stage8=1, win_sum=45, fill_count=9, full=1, out_valid=1. out_valid is 0 after edges 1–8.
- Slide and wrap: then accept 4'hA → stage8=2, win_sum=54, out_valid=1. Accept 4'h0 → win_sum=52.
- Gaps and saturation:
  - Accept 4'hF 12 times with in_valid=0 between each → win_sum=135, fill_count stays 9.
  - Every idle cycle holds all values with out_valid=0.
- Flush collision: after 5 accepts, assert flush with in_valid=1, data_in=4'h7 → all zeros next cycle, fill_count 0, the 7 is dropped. Nine more accepts are then needed for out_valid.
- Tap select: after the fill scenario, sweep tap_sel 0..15 → tap_out = 9,8,…,1 for indices 0–8, and 0 for indices 9–15.

Source files
------------

// File: rtl/sample_window.sv
// sample_window: parametrised sliding-window sample buffer with a running
// window sum, a saturating fill counter and a combinational tap selector.
// Stage 0 holds the newest sample; stage DEPTH-1 the oldest.
module sample_window #(
    parameter  int DATA_W = 4,
    parameter  int DEPTH  = 9,
    localparam int SUM_W  = DATA_W + $clog2(DEPTH),
    localparam int TAP_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [TAP_W-1:0]        tap_sel,
    output logic [DATA_W*DEPTH-1:0] samples,
    output logic [DATA_W-1:0]       tap_out,
    output logic [SUM_W-1:0]        win_sum,
    output logic [CNT_W-1:0]        fill_count,
    output logic                    full,
    output logic                    out_valid
);

    localparam int              SUM_XW   = SUM_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] stage [DEPTH];
    logic [SUM_W-1:0]  sum_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              valid_q;
    logic [SUM_W-1:0]  sum_next;
    logic [CNT_W-1:0]  cnt_next;

    // Next window sum and fill count for an accept; the add/subtract runs one
    // bit wider than the sum so the intermediate never wraps before truncation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sum_next = SUM_W'(SUM_XW'(sum_q) + SUM_XW'(data_in) - SUM_XW'(stage[DEPTH-1]));
        cnt_next = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Window shift register, running sum, fill counter and window-complete pulse.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            // NOTE: the stage array is cleared too, unlike a plain data buffer, because
            // the incremental sum relies on evicted stages reading as zero after a clear.
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            sum_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (in_valid) begin
            // NOTE: non-blocking assignments make every stage read its neighbour's old value.
            stage[0] <= data_in;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
            sum_q   <= sum_next;
            cnt_q   <= cnt_next;
            valid_q <= (cnt_next == CNT_FULL);
        end else begin
            valid_q <= 1'b0;
        end
    end

    // Flatten the stages onto the samples bus, stage k at bits [k*DATA_W +: DATA_W].
    always_comb begin
        samples = '0;
        for (int k = 0; k < DEPTH; k++) begin
            samples[k*DATA_W +: DATA_W] = stage[k];
        end
    end

    // Tap mux; indices past the last stage read as zero.
    always_comb begin
        tap_out = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (tap_sel == TAP_W'(k)) begin
                tap_out = stage[k];
            end
        end
    end

    assign win_sum    = sum_q;
    assign fill_count = cnt_q;
    assign full       = (cnt_q == CNT_FULL);
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_sample_window.sv
// tb_sample_window: scoreboard bench for sample_window at default parameters.
// A behavioural window model pushes the expected post-edge state on every
// driven cycle; the state is popped and compared one step after the edge.
module tb_sample_window;

    localparam int DW  = 4;
    localparam int DP  = 9;
    localparam int SW  = DW + $clog2(DP);
    localparam int TW  = $clog2(DP);
    localparam int CW  = $clog2(DP + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic [DW-1:0]     data_in = '0;
    logic [TW-1:0]     tap_sel = '0;
    logic [DW*DP-1:0]  samples;
    logic [DW-1:0]     tap_out;
    logic [SW-1:0]     win_sum;
    logic [CW-1:0]     fill_count;
    logic              full;
    logic              out_valid;

    typedef struct {
        logic [DW*DP-1:0] samples;
        logic [DW-1:0]    tap;
        logic [SW-1:0]    sum;
        logic [CW-1:0]    cnt;
        logic             full;
        logic             valid;
    } exp_t;

    exp_t sb [$];
    int   m_stage [DP];
    int   m_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    sample_window #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .tap_sel    (tap_sel),
        .samples    (samples),
        .tap_out    (tap_out),
        .win_sum    (win_sum),
        .fill_count (fill_count),
        .full       (full),
        .out_valid  (out_valid)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Global time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one edge and push the expected visible state.
    task automatic model_push(input logic r, input logic f, input logic v, input int d, input int tap);
        exp_t e;
        int   sum;
        logic vld;
        vld = 1'b0;
        if (r || f) begin
            for (int k = 0; k < DP; k++) m_stage[k] = 0;
            m_cnt = 0;
        end else if (v) begin
            for (int k = DP - 1; k > 0; k--) m_stage[k] = m_stage[k-1];
            m_stage[0] = d;
            if (m_cnt < DP) m_cnt++;
            vld = (m_cnt == DP);
        end
        sum = 0;
        e.samples = '0;
        for (int k = 0; k < DP; k++) begin
            sum += m_stage[k];
            e.samples[k*DW +: DW] = DW'(m_stage[k]);
        end
        e.tap   = (tap < DP) ? DW'(m_stage[tap]) : '0;
        e.sum   = SW'(sum);
        e.cnt   = CW'(m_cnt);
        e.full  = (m_cnt == DP);
        e.valid = vld;
        sb.push_back(e);
    endtask

    // One clock of stimulus: drive at negedge, compare scoreboard entry after posedge.
    // tap < 0 picks a random tap index.
    task automatic step(input logic r, input logic f, input logic v, input int d, input int tap);
        exp_t e;
        int   t;
        t = (tap < 0) ? int'($urandom_range(0, 15)) : tap;
        @(negedge clk);
        reset    = r;
        flush    = f;
        in_valid = v;
        data_in  = DW'(d);
        tap_sel  = TW'(t);
        model_push(r, f, v, d, t);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("samples", 64'(samples), 64'(e.samples));
            check("tap_out", 64'(tap_out), 64'(e.tap));
            check("win_sum", 64'(win_sum), 64'(e.sum));
            check("fill_count", 64'(fill_count), 64'(e.cnt));
            check("full", 64'(full), 64'(e.full));
            check("out_valid", 64'(out_valid), 64'(e.valid));
        end
    endtask

    initial begin
        for (int k = 0; k < DP; k++) m_stage[k] = 0;

        // Reset dominance: reset held with a sample presented.
        step(1, 0, 1, 15, -1);
        step(1, 0, 1, 15, -1);
        check("reset_samples", 64'(samples), 64'd0);
        check("reset_sum", 64'(win_sum), 64'd0);

        // Fill with 1..9 back-to-back.
        for (int i = 1; i <= DP; i++) step(0, 0, 1, i, -1);
        check("fill_stage0", 64'(samples[0 +: DW]), 64'd9);
        check("fill_stage8", 64'(samples[8*DW +: DW]), 64'd1);
        check("fill_sum", 64'(win_sum), 64'd45);
        check("fill_full", 64'(full), 64'd1);

        // Tap sweep over every index, including the out-of-range ones.
        for (int k = 0; k < 16; k++) begin
            step(0, 0, 0, 0, k);
            check("tap_sweep", 64'(tap_out), (k < DP) ? 64'(9 - k) : 64'd0);
        end

        // Slide and wrap.
        step(0, 0, 1, 10, -1);
        check("slide_stage8", 64'(samples[8*DW +: DW]), 64'd2);
        check("slide_sum", 64'(win_sum), 64'd54);
        check("slide_valid", 64'(out_valid), 64'd1);
        step(0, 0, 1, 0, -1);
        check("slide_sum0", 64'(win_sum), 64'd52);

        // Gaps and saturation: maximum samples separated by idle cycles.
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 15, -1);
            step(0, 0, 0, 3, -1);
        end
        check("sat_sum", 64'(win_sum), 64'd135);
        check("sat_count", 64'(fill_count), 64'd9);

        // Flush collision mid-fill, then a full refill.
        step(0, 1, 0, 0, -1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, i + 3, -1);
        step(0, 1, 1, 7, -1);
        check("flush_samples", 64'(samples), 64'd0);
        check("flush_count", 64'(fill_count), 64'd0);
        for (int i = 0; i < DP; i++) step(0, 0, 1, int'($urandom_range(0, 15)), -1);
        check("refill_valid", 64'(out_valid), 64'd1);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
